// File: rtl/ntt_poly_collector_if.sv
// Handshake and result bus between the NTT read-out stream and the polynomial collector.
// master drives the coefficient stream and control; slave is the collector.
interface ntt_poly_collector_if #(
  parameter int K      = 3,
  parameter int N_COEF = 256,
  parameter int COEF_W = 12,
  parameter int SLOT_W = (K > 1) ? $clog2(K) : 1
);

  logic                                     start_i;
  logic [SLOT_W-1:0]                        slot_i;
  logic                                     coef_valid_i;
  logic [COEF_W-1:0]                        coef_i;
  logic                                     clear_i;
  logic [K-1:0][N_COEF-1:0][COEF_W-1:0]     polyvec_o;
  logic [K-1:0]                             slot_valid_o;
  logic                                     busy_o;
  logic                                     done_o;
  logic                                     err_o;

  modport master (
    output start_i, slot_i, coef_valid_i, coef_i, clear_i,
    input  polyvec_o, slot_valid_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, slot_i, coef_valid_i, coef_i, clear_i,
    output polyvec_o, slot_valid_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/ntt_poly_collector.sv
// Collects a 256-beat coefficient stream, reduces each beat mod Q and commits the
// assembled polynomial into one slot of a K-entry polynomial vector register.
module ntt_poly_collector #(
  parameter int K      = 3,
  parameter int N_COEF = 256,
  parameter int COEF_W = 12,
  parameter int Q      = 3329
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  ntt_poly_collector_if.slave bus
);

  localparam int SLOT_W = (K > 1) ? $clog2(K) : 1;
  localparam int CNT_W  = $clog2(N_COEF + 1);

  localparam logic [COEF_W-1:0] Q_W      = COEF_W'(Q);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_COEF - 1);
  localparam logic [SLOT_W:0]   K_EXT    = (SLOT_W + 1)'(K);

  typedef logic [N_COEF-1:0][COEF_W-1:0] poly_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2
  } state_e;

  state_e                state_q,      state_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic [SLOT_W-1:0]     slot_q,       slot_d;
  poly_t                 buf_q,        buf_d;
  poly_t [K-1:0]         polyvec_q,    polyvec_d;
  logic [K-1:0]          slot_valid_q, slot_valid_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;
  logic                  err_q,        err_d;
  logic                  slot_oob_s;

  // Single conditional subtraction suffices: any 12-bit input is below 2*Q.
  function automatic logic [COEF_W-1:0] red_coef(input logic [COEF_W-1:0] x);
    logic [COEF_W-1:0] r;
    if (x >= Q_W) begin
      r = x - Q_W;
    end else begin
      r = x;
    end
    return r;
  endfunction

  assign slot_oob_s = ({1'b0, bus.slot_i} >= K_EXT);

  // Next-state and output decode; clear_i overrides every state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    buf_d        = buf_q;
    polyvec_d    = polyvec_q;
    slot_valid_d = slot_valid_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    if (bus.clear_i) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      slot_valid_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && !slot_oob_s) begin
            slot_d  = bus.slot_i;
            cnt_d   = '0;
            state_d = S_COLLECT;
          end else begin
            state_d = S_IDLE;
          end
          err_d = (bus.start_i && slot_oob_s) || bus.coef_valid_i;
        end
        S_COLLECT: begin
          err_d = bus.start_i;
          if (bus.coef_valid_i) begin
            buf_d = {red_coef(bus.coef_i), buf_q[N_COEF-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = S_COMMIT;
            end else begin
              state_d = S_COLLECT;
            end
          end else begin
            state_d = S_COLLECT;
          end
        end
        S_COMMIT: begin
          polyvec_d[slot_q]    = buf_q;
          slot_valid_d[slot_q] = 1'b1;
          done_d               = 1'b1;
          err_d                = bus.coef_valid_i || bus.start_i;
          state_d              = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      slot_q       <= '0;
      buf_q        <= '0;
      polyvec_q    <= '0;
      slot_valid_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      buf_q        <= buf_d;
      polyvec_q    <= polyvec_d;
      slot_valid_q <= slot_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.polyvec_o    = polyvec_q;
  assign bus.slot_valid_o = slot_valid_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;

endmodule
